lix_shr_arb: RTL and testbench



---
 rtl/lix_shr_arb.sv | 73 +++++++
 tb/tb_lix_shr_arb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lix_shr_arb.sv
// lix_shr_arb: two-requester round-robin scheduler with shadow valid/ID tracking and flush/drain for a fixed-latency pipeline
module lix_shr_arb #(
  parameter int W = 32,
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req0_vld,
  output logic         req0_rdy,
  input  logic [W-1:0] req0_x,
  input  logic         req1_vld,
  output logic         req1_rdy,
  input  logic [W-1:0] req1_x,
  input  logic         flush_i,
  output logic         p_vld,
  output logic         p_en,
  output logic [W-1:0] p_x,
  input  logic [W-1:0] p_z,
  output logic         o_vld,
  input  logic         o_rdy,
  output logic         o_id,
  output logic [W-1:0] o_z,
  output logic         o_busy,
  output logic         o_drained
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic last, grant, ok, acc, hs;
  logic [N-1:0] sh_v, sh_id;
  logic [CW-1:0] cnt, cnt_nxt;
  assign o_vld = sh_v[N-1];
  assign o_id = sh_id[N-1];
  assign o_z = p_z;
  assign p_en = o_rdy | ~o_vld;
  assign grant = req1_vld & (~req0_vld | ~last);
  assign ok = p_en & (state != DRAIN) & ~flush_i;
  assign req0_rdy = ok & ~grant;
  assign req1_rdy = ok & grant;
  assign acc = ok & (req0_vld | req1_vld);
  assign p_vld = acc;
  assign p_x = grant ? req1_x : req0_x;
  assign hs = o_vld & o_rdy;
  assign cnt_nxt = cnt + CW'(acc) - CW'(hs);
  assign o_busy = cnt != '0;
  assign o_drained = (state == IDLE) & flush_i;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = acc ? RUN : (flush_i && cnt != '0) ? DRAIN : IDLE;
      RUN:     state_nxt = (cnt_nxt == '0 && !acc) ? IDLE : flush_i ? DRAIN : RUN;
      DRAIN:   state_nxt = (cnt_nxt == '0) ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last <= 1'b1;
      cnt <= '0;
      sh_v <= '0;
      sh_id <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (acc) last <= grant;
      if (p_en) begin
        sh_v <= N'({sh_v, acc});
        sh_id <= N'({sh_id, grant});
      end
    end
  end
endmodule

// File: tb/tb_lix_shr_arb.sv
// tb_lix_shr_arb: randomized and directed self-checking bench with a token-queue reference model
module tb_lix_shr_arb;
  localparam int W = 8;
  localparam int N = 3;
  logic clk = 0;
  logic rst_i, req0_vld, req1_vld, req0_rdy, req1_rdy, flush_i;
  logic [W-1:0] req0_x, req1_x, p_x, p_z, o_z;
  logic p_vld, p_en, o_vld, o_rdy, o_id, o_busy, o_drained;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  logic [W-1:0] pipe [N];
  always @(posedge clk) if (p_en) begin
    for (int i = N - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= p_x;
  end
  assign p_z = pipe[N-1];
  lix_shr_arb #(.W(W), .N(N)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_x(req0_x),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_x(req1_x),
    .flush_i(flush_i), .p_vld(p_vld), .p_en(p_en), .p_x(p_x), .p_z(p_z),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_id(o_id), .o_z(o_z),
    .o_busy(o_busy), .o_drained(o_drained)
  );
  typedef struct {logic id; logic [W-1:0] x; int adv;} tok_t;
  typedef struct {logic id; logic [W-1:0] z;} out_t;
  tok_t q[$];
  out_t log_q[$];
  logic m_last = 1'b1;
  logic m_drain = 1'b0;
  bit live = 0;
  logic e_ovld, e_id, e_en, e_g, e_r0, e_r1, e_acc, e_ok;
  logic [W-1:0] e_z, e_px;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
    end
  endtask
  // A token is at the output once it has seen N enabled edges, counting its accept edge.
  function automatic void calc();
    e_ovld = q.size() > 0 && q[0].adv == N;
    e_id = e_ovld ? q[0].id : 1'b0;
    e_z = e_ovld ? q[0].x : '0;
    e_en = o_rdy | ~e_ovld;
    e_g = (req0_vld & req1_vld) ? ~m_last : req1_vld;
    e_ok = e_en & ~m_drain & ~flush_i;
    e_r0 = e_ok & ~e_g;
    e_r1 = e_ok & e_g;
    e_acc = e_g ? (req1_vld & e_r1) : (req0_vld & e_r0);
    e_px = e_g ? req1_x : req0_x;
  endfunction
  always @(negedge clk) begin
    if (live) begin
      calc();
      chk("p_en", p_en, e_en);
      chk("req0_rdy", req0_rdy, e_r0);
      chk("req1_rdy", req1_rdy, e_r1);
      chk("p_vld", p_vld, e_acc);
      chk("o_vld", o_vld, e_ovld);
      chk("o_busy", o_busy, q.size() != 0);
      chk("o_drained", o_drained, flush_i & (q.size() == 0));
      if (e_acc) chk("p_x", p_x, e_px);
      if (e_ovld) begin
        chk("o_id", o_id, e_id);
        chk("o_z", o_z, e_z);
      end
    end
    if (rst_i) begin
      q.delete();
      m_last = 1'b1;
      m_drain = 1'b0;
      live = 1;
    end else if (live) begin
      if (o_vld & o_rdy) log_q.push_back('{o_id, o_z});
      if (e_ovld & o_rdy) void'(q.pop_front());
      if (e_en) foreach (q[i]) q[i].adv++;
      if (e_acc) begin
        q.push_back('{e_g, e_px, 1});
        m_last = e_g;
      end
      m_drain = q.size() != 0 && (m_drain || flush_i);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int base, w, i0, i1;
    logic a0, a1, hid;
    logic [W-1:0] hz;
    logic [W-1:0] d0 [2];
    logic [W-1:0] d1 [2];
    logic [W-1:0] ez [4];
    logic ei [4];
    d0 = '{8'h10, 8'h11};
    d1 = '{8'h20, 8'h21};
    ez = '{8'h10, 8'h20, 8'h11, 8'h21};
    ei = '{1'b0, 1'b1, 1'b0, 1'b1};
    req0_vld = 0; req1_vld = 0; req0_x = 0; req1_x = 0;
    flush_i = 0; o_rdy = 1; rst_i = 1;
    repeat (3) step();
    rst_i = 0;
    @(negedge clk);
    chk("rst_o_vld", o_vld, 0);
    chk("rst_o_busy", o_busy, 0);
    chk("rst_p_en", p_en, 1);
    chk("rst_req0_rdy", req0_rdy, 1);
    chk("rst_req1_rdy", req1_rdy, 0);
    chk("rst_drained", o_drained, 0);
    chk("rst_p_vld", p_vld, 0);
    step();
    req0_vld = 1; req0_x = 8'h5A;
    @(negedge clk);
    chk("single_rdy", req0_rdy, 1);
    chk("single_p_vld", p_vld, 1);
    step();
    req0_vld = 0;
    @(negedge clk);
    chk("single_busy", o_busy, 1);
    chk("single_early", o_vld, 0);
    step();
    step();
    @(negedge clk);
    chk("single_o_vld", o_vld, 1);
    chk("single_o_id", o_id, 0);
    chk("single_o_z", o_z, 8'h5A);
    chk("single_busy2", o_busy, 1);
    step();
    @(negedge clk);
    chk("single_done", o_busy, 0);
    step();
    rst_i = 1;
    step();
    rst_i = 0;
    base = log_q.size();
    i0 = 0; i1 = 0;
    req0_vld = 1; req1_vld = 1;
    for (int k = 0; k < 4; k++) begin
      req0_x = d0[i0]; req1_x = d1[i1];
      @(negedge clk);
      a0 = req0_rdy; a1 = req1_rdy;
      step();
      if (a0 && i0 < 1) i0++;
      if (a1 && i1 < 1) i1++;
    end
    req0_vld = 0; req1_vld = 0;
    repeat (N + 2) step();
    chk("rr_count", log_q.size() - base, 4);
    for (int k = 0; k < 4; k++) if (base + k < log_q.size()) begin
      chk("rr_id", log_q[base+k].id, ei[k]);
      chk("rr_z", log_q[base+k].z, ez[k]);
    end
    base = log_q.size();
    req0_vld = 1;
    for (int k = 0; k < 5; k++) begin
      req0_x = W'($urandom);
      step();
    end
    o_rdy = 0;
    @(negedge clk);
    hid = o_id; hz = o_z;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_p_en", p_en, 0);
      chk("stall_rdy", req0_rdy | req1_rdy, 0);
      chk("stall_o_vld", o_vld, 1);
      chk("stall_hold_id", o_id, hid);
      chk("stall_hold_z", o_z, hz);
      step();
    end
    o_rdy = 1; req0_vld = 0;
    repeat (N + 3) step();
    chk("stall_count", log_q.size() - base, 5);
    base = log_q.size();
    req0_vld = 1;
    for (int k = 0; k < 3; k++) begin
      req0_x = W'($urandom);
      step();
    end
    req0_vld = 0; flush_i = 1; req1_vld = 1;
    @(negedge clk);
    chk("flush_req1_rdy", req1_rdy, 0);
    chk("flush_p_vld", p_vld, 0);
    w = 0;
    while (!o_drained && w < 20) begin
      step();
      @(negedge clk);
      w++;
    end
    chk("flush_drained", o_drained, 1);
    step();
    chk("flush_count", log_q.size() - base, 3);
    flush_i = 0; req1_vld = 0;
    step();
    base = log_q.size();
    req0_vld = 1;
    step();
    step();
    req0_vld = 0; rst_i = 1;
    step();
    rst_i = 0;
    for (int k = 0; k < N + 1; k++) begin
      @(negedge clk);
      chk("rmid_o_vld", o_vld, 0);
      chk("rmid_busy", o_busy, 0);
      step();
    end
    chk("rmid_count", log_q.size() - base, 0);
    req0_vld = 1; req1_vld = 1;
    @(negedge clk);
    chk("rmid_req0_rdy", req0_rdy, 1);
    chk("rmid_req1_rdy", req1_rdy, 0);
    step();
    req0_vld = 0; req1_vld = 0;
    for (int k = 0; k < 4000; k++) begin
      req0_vld = 1'($urandom_range(0, 1));
      req1_vld = 1'($urandom_range(0, 1));
      req0_x = W'($urandom);
      req1_x = W'($urandom);
      o_rdy = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 39) == 0) flush_i = ~flush_i;
      rst_i = $urandom_range(0, 699) == 0;
      step();
    end
    rst_i = 0; flush_i = 0; req0_vld = 0; req1_vld = 0; o_rdy = 1;
    repeat (N + 3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
